// File: rtl/iuq_cpl_pkg.sv
// Shared constants and types for the IU completion-array allocation/retirement logic.
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 2
`endif

package iuq_cpl_pkg;
    localparam int CPL_ENTRIES = 64;
    localparam int CPL_ADDR_W  = 6;
    localparam int CPL_RD_LAT  = 2;

    typedef logic [CPL_ADDR_W-1:0] cpl_itag_t;

    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {1'b0, v[1]} + {1'b0, v[0]};
    endfunction
endpackage

// File: rtl/iuq_cpl_cmp_dly.sv
// Completion valid/itag delay line matching the completion array's registered read path.
module iuq_cpl_cmp_dly
    import iuq_cpl_pkg::*;
#(
    parameter int LAT    = CPL_RD_LAT,
    parameter int ADDR_W = CPL_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_vld,
    input  logic [ADDR_W-1:0] i_itag,
    output logic [1:0]        o_vld,
    output logic [ADDR_W-1:0] o_itag
);
    logic [1:0]        r_vld_p  [LAT];
    logic [ADDR_W-1:0] r_itag_p [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_vld_p[i]  <= '0;
                r_itag_p[i] <= '0;
            end
        end else begin
            r_vld_p[0]  <= i_vld;
            r_itag_p[0] <= i_itag;
            for (int i = 1; i < LAT; i++) begin
                r_vld_p[i]  <= r_vld_p[i-1];
                r_itag_p[i] <= r_itag_p[i-1];
            end
        end
    end

    assign o_vld  = r_vld_p[LAT-1];
    assign o_itag = r_itag_p[LAT-1];
endmodule

// File: rtl/iuq_cpl_alloc_ctl.sv
// Completion-array itag allocator and in-order retirement controller (two-wide dispatch and retire).
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 2
`endif

module iuq_cpl_alloc_ctl
    import iuq_cpl_pkg::*;
#(
    parameter int ENTRIES = CPL_ENTRIES,
    parameter int ADDR_W  = CPL_ADDR_W,
    parameter int RD_LAT  = CPL_RD_LAT
) (
    input  logic [`NCLK_WIDTH-1:0] nclk,
    input  logic [1:0]             disp_val,
    output logic                   disp_ready,
    output logic [ADDR_W-1:0]      disp_itag,
    input  logic                   fin_val,
    input  logic [ADDR_W-1:0]      fin_itag,
    input  logic                   flush,
    output logic                   we0,
    output logic                   we1,
    output logic [ADDR_W-1:0]      wa0,
    output logic [ADDR_W-1:0]      wa1,
    output logic                   re0,
    output logic                   re1,
    output logic [ADDR_W-1:0]      ra0,
    output logic [ADDR_W-1:0]      ra1,
    output logic [1:0]             cmp_val,
    output logic [ADDR_W-1:0]      cmp_itag,
    output logic [ADDR_W:0]        free_cnt
);
    logic w_clk;
    logic w_rst;
    assign w_clk = nclk[0];
    assign w_rst = nclk[1];

    logic [ADDR_W-1:0]  r_head;
    logic [ADDR_W-1:0]  r_tail;
    logic [ADDR_W:0]    r_free;
    logic               r_disp_ready;
    logic [ENTRIES-1:0] r_val;
    logic [ENTRIES-1:0] r_fin;

    logic               w_acc;
    logic               w_we0;
    logic               w_we1;
    logic               w_h0;
    logic               w_h1;
    logic [ADDR_W-1:0]  w_tail1;
    logic [ADDR_W-1:0]  w_head1;
    logic [1:0]         w_dcnt;
    logic [1:0]         w_rcnt;
    logic [ADDR_W-1:0]  w_head_d;
    logic [ADDR_W-1:0]  w_tail_d;
    logic [ADDR_W+1:0]  w_free_x;
    logic [ADDR_W:0]    w_free_d;
    logic               w_free_bad;
    logic [ENTRIES-1:0] w_val_d;
    logic [ENTRIES-1:0] w_fin_d;

    // Dispatch: writes go straight to the array, which latches them at the next edge.
    assign w_acc   = r_disp_ready & ~flush;
    assign w_we0   = w_acc & disp_val[0];
    assign w_we1   = w_acc & disp_val[1];
    assign w_tail1 = r_tail + ADDR_W'(1);
    assign w_head1 = r_head + ADDR_W'(1);

    // Retire only a contiguous finished prefix starting at head; flush kills the decision.
    assign w_h0 = ~flush & r_val[r_head] & r_fin[r_head];
    assign w_h1 = w_h0 & r_val[w_head1] & r_fin[w_head1];

    assign w_dcnt   = pop2({w_we1, w_we0});
    assign w_rcnt   = pop2({w_h1, w_h0});
    assign w_head_d = r_head + ADDR_W'(w_rcnt);
    assign w_tail_d = flush ? r_head : (r_tail + ADDR_W'(w_dcnt));

    // One extra bit so an underflow shows up as a large value rather than wrapping silently.
    assign w_free_x   = {1'b0, r_free} - (ADDR_W+2)'(w_dcnt) + (ADDR_W+2)'(w_rcnt);
    assign w_free_bad = w_free_x > (ADDR_W+2)'(ENTRIES);
    assign w_free_d   = flush ? (ADDR_W+1)'(ENTRIES) : w_free_x[ADDR_W:0];

    always_comb begin
        w_val_d = r_val;
        w_fin_d = r_fin;
        if (fin_val && r_val[fin_itag]) begin
            w_fin_d[fin_itag] = 1'b1;
        end
        if (w_h0) begin
            w_val_d[r_head] = 1'b0;
            w_fin_d[r_head] = 1'b0;
        end
        if (w_h1) begin
            w_val_d[w_head1] = 1'b0;
            w_fin_d[w_head1] = 1'b0;
        end
        if (w_we0) begin
            w_val_d[r_tail] = 1'b1;
            w_fin_d[r_tail] = 1'b0;
        end
        if (w_we1) begin
            w_val_d[w_tail1] = 1'b1;
            w_fin_d[w_tail1] = 1'b0;
        end
        if (flush) begin
            w_val_d = '0;
            w_fin_d = '0;
        end
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_free       <= (ADDR_W+1)'(ENTRIES);
            r_disp_ready <= 1'b1;
            r_val        <= '0;
            r_fin        <= '0;
        end else begin
            r_head       <= w_head_d;
            r_tail       <= w_tail_d;
            r_free       <= w_free_d;
            r_disp_ready <= (w_free_d >= (ADDR_W+1)'(2));
            r_val        <= w_val_d;
            r_fin        <= w_fin_d;
        end
    end

    a_free_range: assert property (@(posedge w_clk) disable iff (w_rst) !w_free_bad);

    iuq_cpl_cmp_dly #(
        .LAT    (RD_LAT),
        .ADDR_W (ADDR_W)
    ) u_cmp_dly (
        .clk    (w_clk),
        .rst    (w_rst),
        .i_vld  ({w_h1, w_h0}),
        .i_itag (r_head),
        .o_vld  (cmp_val),
        .o_itag (cmp_itag)
    );

    assign disp_ready = r_disp_ready;
    assign disp_itag  = r_tail;
    assign free_cnt   = r_free;
    assign we0        = w_we0;
    assign we1        = w_we1;
    assign wa0        = r_tail;
    assign wa1        = w_tail1;
    assign re0        = w_h0;
    assign re1        = w_h1;
    assign ra0        = r_head;
    assign ra1        = w_head1;
endmodule

// File: doc/iuq_cpl_alloc_ctl.md
# iuq_cpl_alloc_ctl

Allocation and in-order retirement controller for the 64-entry IU completion array. It hands out consecutive itags to up to two dispatched instructions per cycle and drives the array's two write ports. It records finish reports per entry and retires up to two oldest finished entries per cycle through the array's two read ports. Completion valids are delayed so they line up with the array's registered read data.

## Interface
Parameters:
- ENTRIES, 64, completion-array depth; power of two.
- ADDR_W, 6, itag / array address width; log2(ENTRIES).
- RD_LAT, 2, array read latency: address latch plus data latch.

Ports:
- nclk  in  `NCLK_WIDTH  bit 0 clock; bit 1 reset, asynchronous and active-high.
- disp_val  in  2  dispatch slot valids; [1] only legal with [0].
- disp_ready  out  1  free count ≥ 2; reset 1.
- disp_itag  out  ADDR_W  itag given to slot 0; slot 1 gets disp_itag+1 mod ENTRIES; reset 0.
- fin_val  in  1  finish report valid.
- fin_itag  in  ADDR_W  finished itag.
- flush  in  1  discard all uncompleted entries.
- we0, we1  out  1 each  array write enables; reset 0.
- wa0, wa1  out  ADDR_W each  array write addresses; reset 0, 1.
- re0, re1  out  1 each  array read enables; reset 0.
- ra0, ra1  out  ADDR_W each  array read addresses; reset 0, 1.
- cmp_val  out  2  completion valids aligned with array do0/do1; reset 0.
- cmp_itag  out  ADDR_W  itag of cmp slot 0; reset 0.
- free_cnt  out  ADDR_W+1  free entries; reset ENTRIES.

## Operation
State:
- head_q and tail_q pointers, ADDR_W bits each. Wrap ENTRIES-1 → 0 is natural overflow.
- free_q counter, ADDR_W+1 bits.
- val_q and fin_q, ENTRIES bits each.
- cmp pipeline, RD_LAT stages.

Array pairing rule: the array holds even and odd banks. Every cycle, wa1 = wa0+1 and ra1 = ra0+1, mod ENTRIES. This holds even when only port 0 is enabled.

Dispatch, accepted when disp_ready & ~flush:
- we0 = disp_val[0]; we1 = disp_val[1].
- wa0 = tail_q.
- tail advances by popcount(disp_val).
- Accepted entries get val set and fin cleared.
- disp_val while disp_ready=0 is a protocol violation. It is ignored and produces no write.

Finish:
- fin_val sets fin_q[fin_itag] next cycle, only if val_q[fin_itag]=1. Otherwise it is ignored.

Retire decision, from registered state, suppressed when flush=1:
- h0 = val_q[head_q] & fin_q[head_q].
- h1 = h0 & val_q[head_q+1] & fin_q[head_q+1].
- re0 = h0; re1 = h1; ra0 = head_q.
- Retired entries clear val and fin.
- head advances by h0+h1.
- Stage-0 pipe captures {h0,h1,head_q}.

Free count:
- free_d = free_q − popcount(accepted disp) + (h0+h1).
- It stays within 0..ENTRIES. Any other result is an assertion failure.

Flush:
- Clears all val and fin bits, sets tail_q ← head_q, sets free_q ← ENTRIES.
- Dispatch and retirement in the flush cycle are suppressed.
- Retirements already in the cmp pipe still deliver.

Reset mid-operation: all state returns to reset values immediately, and pipe stages clear.

## Timing
- Write enables and addresses are combinational from registered tail_q and disp_val. The array latches them, so an entry is written at edge+1.
- A finish in cycle N updates fin_q at edge N+1. The earliest retire decision is cycle N+1.
- A retire decision in cycle N puts cmp_val/cmp_itag at cycle N+RD_LAT, coincident with array do0/do1. cmp_val and cmp_itag are registered.
- Freed entries count toward disp_ready the cycle after the decision.
- disp_ready and free_cnt are registered outputs.
- Dispatch writing an entry in cycle N can complete no earlier than N+2: finish at N+1, decision at N+2.

## Structure
- Shared package iuq_cpl_pkg holds CPL_ENTRIES, CPL_ADDR_W, CPL_RD_LAT, and the itag type.
- Sub-module iuq_cpl_cmp_dly: RD_LAT-deep valid/itag shift pipe with async reset. Used once.

## Test plan
- Reset: free_cnt=64, disp_ready=1, wa0/wa1=0/1, ra0/ra1=0/1, all enables and cmp_val 0.
- Dual dispatch ×32 (itags 0..63) → free_cnt=0 and disp_ready=0. A further disp_val=2'b11 produces no write and tail stays 0.
- Finish itags 1 then 0 → no retire before both are set, then one cycle with re0=re1=1, ra0=0, ra1=1. cmp_val=2'b11 and cmp_itag=0 exactly 2 cycles later.
- Wrap: head=63 with 63 and 0 finished → ra0=63, ra1=0, head → 1.
- Finish of an unallocated itag 10 → ignored. After itag 10 is later dispatched it is not retired until a new finish arrives.
- Flush with 5 entries live and a retire in flight → the in-flight cmp_val still appears. tail=head, free_cnt=64, no further retirements.
